// File: rtl/shift_cmd_seq_if.sv
// Command/result bundle for the serial shifter front-end.
// Optional feature macro: SHIFT_ROTATE_EN adds the cmd_rot signal.
interface shift_cmd_seq_if #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 6
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_data;
   logic [AMT_W-1:0] cmd_amt;
   logic             cmd_dir;
`ifdef SHIFT_ROTATE_EN
   logic             cmd_rot;
`endif
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             busy;

`ifdef SHIFT_ROTATE_EN
   modport master (
      output cmd_valid, cmd_data, cmd_amt,
      output cmd_dir, cmd_rot, res_ready,
      input  cmd_ready, res_valid, res_data, busy
   );
   modport slave (
      input  cmd_valid, cmd_data, cmd_amt,
      input  cmd_dir, cmd_rot, res_ready,
      output cmd_ready, res_valid, res_data, busy
   );
`else
   modport master (
      output cmd_valid, cmd_data, cmd_amt,
      output cmd_dir, res_ready,
      input  cmd_ready, res_valid, res_data, busy
   );
   modport slave (
      input  cmd_valid, cmd_data, cmd_amt,
      input  cmd_dir, res_ready,
      output cmd_ready, res_valid, res_data, busy
   );
`endif
endinterface

// File: rtl/shift_cmd_seq.sv
// Serial shift-command sequencer: FIFO-buffered requests, one bit per clk.
// Optional feature macro: SHIFT_ROTATE_EN enables per-command rotate.
module shift_cmd_seq #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 6,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           clr,
   shift_cmd_seq_if.slave bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);
   localparam logic [AMT_W-1:0] LP_W    = AMT_W'(WIDTH);
   localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WIDTH-1:0] r_mem_data [DEPTH];
   logic [AMT_W-1:0] r_mem_amt  [DEPTH];
   logic             r_mem_dir  [DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;

   logic [WIDTH-1:0] r_shreg;
   logic [AMT_W-1:0] r_cnt;
   logic             r_dir;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_head_data;
   logic [AMT_W-1:0] w_head_amt;
   logic             w_head_dir;
   logic             w_head_rot;
   logic             w_cur_rot;
   logic [AMT_W-1:0] w_eff;
   logic [WIDTH-1:0] w_shifted;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

   // Full alone gates acceptance, so a same-cycle pop never frees a slot early.
   assign w_push = bus.cmd_valid && !w_full;

   assign w_head_data = r_mem_data[r_rd_ptr[PTR_W-1:0]];
   assign w_head_amt  = r_mem_amt[r_rd_ptr[PTR_W-1:0]];
   assign w_head_dir  = r_mem_dir[r_rd_ptr[PTR_W-1:0]];

`ifdef SHIFT_ROTATE_EN
   logic r_mem_rot [DEPTH];
   logic r_rot;

   // Rotate flag travels with its command through the queue.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_rot[r_wr_ptr[PTR_W-1:0]] <= bus.cmd_rot;
      end
   end

   // Rotate flag of the command currently in the engine.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_rot <= 1'b0;
      end else if (w_pop) begin
         r_rot <= w_head_rot;
      end
   end

   assign w_head_rot = r_mem_rot[r_rd_ptr[PTR_W-1:0]];
   assign w_cur_rot  = r_rot;
`else
   assign w_head_rot = 1'b0;
   assign w_cur_rot  = 1'b0;
`endif

   // Queue storage; contents need no reset since the pointers gate them.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr[PTR_W-1:0]] <= bus.cmd_data;
         r_mem_amt[r_wr_ptr[PTR_W-1:0]]  <= bus.cmd_amt;
         r_mem_dir[r_wr_ptr[PTR_W-1:0]]  <= bus.cmd_dir;
      end
   end

   // Queue pointers carry an extra wrap bit to tell full from empty.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Step count: logical shifts saturate at WIDTH, rotates wrap modulo WIDTH.
   always_comb begin
      w_eff = w_head_amt;
      if (w_head_rot) begin
         w_eff = w_head_amt % LP_W;
      end else if (w_head_amt >= LP_W) begin
         w_eff = LP_W;
      end
   end

   // One-position move of the working register.
   always_comb begin
      w_shifted = r_shreg;
      unique case ({r_dir, w_cur_rot})
         2'b00: w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
         2'b01: w_shifted = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
         2'b10: w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
         2'b11: w_shifted = {r_shreg[0], r_shreg[WIDTH-1:1]};
         default: w_shifted = r_shreg;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and pop strobe; a zero-step command skips straight to DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = (w_eff == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == CNT_ONE) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (bus.res_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: load on pop, then one shift and one decrement per edge.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_shreg <= '0;
         r_cnt   <= '0;
         r_dir   <= 1'b0;
      end else if (w_pop) begin
         r_shreg <= w_head_data;
         r_cnt   <= w_eff;
         r_dir   <= w_head_dir;
      end else if (r_state == S_SHIFT) begin
         r_shreg <= w_shifted;
         r_cnt   <= r_cnt - CNT_ONE;
      end
   end

   assign bus.cmd_ready = !w_full;
   assign bus.res_valid = (r_state == S_DONE);
   assign bus.res_data  = r_shreg;
   assign bus.busy      = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Directed and randomized checks for shift_cmd_seq.
// Build with SHIFT_ROTATE_EN to also cover rotate commands.
module tb_shift_cmd_seq;

   localparam int W  = 32;
   localparam int AW = 6;

   logic clk;
   logic clr;
   int   n_checks;
   int   n_errors;

   shift_cmd_seq_if #(.WIDTH(W), .AMT_W(AW)) bus ();

   shift_cmd_seq #(.WIDTH(W), .AMT_W(AW), .DEPTH(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, exp finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                             input logic [5:0] a,
                                             input logic dir,
                                             input logic rot);
      logic [63:0] dd;
      int e;
      if (rot) begin
         e = int'(a) % 32;
         if (dir) begin
            dd = {d, d} >> e;
            return dd[31:0];
         end
         dd = {d, d} << e;
         return dd[63:32];
      end
      if (a >= 6'd32) return 32'h0;
      return dir ? (d >> a) : (d << a);
   endfunction

   // One command with an idle engine; checks result and latency.
   task automatic run_one(input string tag, input logic [31:0] d,
                          input logic [5:0] a, input logic dir,
                          input logic [31:0] exp, input int exp_lat);
      int lat;
      bus.cmd_data  = d;
      bus.cmd_amt   = a;
      bus.cmd_dir   = dir;
      bus.cmd_valid = 1'b1;
      bus.res_ready = 1'b1;
      chk({tag, "_rdy"}, 64'(bus.cmd_ready), 64'd1);
      step();
      bus.cmd_valid = 1'b0;
      lat = 0;
      while (!bus.res_valid && lat < 100) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_res"}, 64'(bus.res_data), 64'(exp));
      step();
   endtask

   logic [31:0] bp_d [6];
   logic [5:0]  bp_a [6];
   logic        bp_r [6];
   logic [31:0] bp_e [5];
   logic [31:0] q [$];
   logic        m_rot;
   int          k;
   int          got;
   int          cyc;
   int          sent;
   int          recv;
   logic        acc;

   initial begin
      n_checks = 0;
      n_errors = 0;
      clr = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
      bus.cmd_amt   = '0;
      bus.cmd_dir   = 1'b0;
`ifdef SHIFT_ROTATE_EN
      bus.cmd_rot   = 1'b0;
`endif
      bus.res_ready = 1'b0;

      #2;
      chk("rst_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_busy",  64'(bus.busy),      64'd0);
      chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
      chk("rst_data",  64'(bus.res_data),  64'd0);
      #10 clr = 1'b1;
      step();

      run_one("left4",  32'h1a6, 6'd4, 1'b0, 32'h1a60, 5);
      run_one("right4", 32'h1a6, 6'd4, 1'b1, 32'h1a,   5);
      run_one("zero",   32'h1a6, 6'd0, 1'b0, 32'h1a6,  1);
      run_one("sat40",  32'hFFFF_FFFF, 6'd40, 1'b0, 32'h0, 33);
      run_one("left31", 32'h3, 6'd31, 1'b0, 32'h8000_0000, 32);

      bp_d[0] = 32'h1;         bp_a[0] = 6'd1;  bp_r[0] = 1'b0;
      bp_d[1] = 32'h80;        bp_a[1] = 6'd3;  bp_r[1] = 1'b1;
      bp_d[2] = 32'hF0F0;      bp_a[2] = 6'd8;  bp_r[2] = 1'b0;
      bp_d[3] = 32'hFFFF_0000; bp_a[3] = 6'd16; bp_r[3] = 1'b1;
      bp_d[4] = 32'h1234_5678; bp_a[4] = 6'd0;  bp_r[4] = 1'b0;
      bp_d[5] = 32'hDEAD;      bp_a[5] = 6'd1;  bp_r[5] = 1'b0;
      bp_e[0] = 32'h2;
      bp_e[1] = 32'h10;
      bp_e[2] = 32'hF0_F000;
      bp_e[3] = 32'hFFFF;
      bp_e[4] = 32'h1234_5678;

      bus.res_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 8; c++) begin
         if (k < 6) begin
            bus.cmd_data  = bp_d[k];
            bus.cmd_amt   = bp_a[k];
            bus.cmd_dir   = bp_r[k];
            bus.cmd_valid = 1'b1;
         end
         acc = bus.cmd_valid && bus.cmd_ready;
         step();
         if (acc) k++;
      end
      chk("bp_accepted", 64'(k), 64'd5);
      chk("bp_full", 64'(bus.cmd_ready), 64'd0);
      chk("bp_valid", 64'(bus.res_valid), 64'd1);
      chk("bp_hold0", 64'(bus.res_data), 64'(bp_e[0]));
      bus.cmd_data = 32'h5555_5555;
      bus.cmd_amt  = 6'd2;
      repeat (3) step();
      chk("bp_hold1", 64'(bus.res_data), 64'(bp_e[0]));
      chk("bp_full2", 64'(bus.cmd_ready), 64'd0);
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      got = 0;
      cyc = 0;
      while (got < 5 && cyc < 200) begin
         if (bus.res_valid) begin
            chk("bp_res", 64'(bus.res_data), 64'(bp_e[got]));
            got++;
         end
         step();
         cyc++;
      end
      chk("bp_count", 64'(got), 64'd5);
      chk("bp_ready_end", 64'(bus.cmd_ready), 64'd1);
      chk("bp_busy_end", 64'(bus.busy), 64'd0);
      repeat (2) step();
      chk("bp_no_extra", 64'(bus.res_valid), 64'd0);

      k = 0;
      for (int c = 0; c < 4; c++) begin
         bus.cmd_data  = 32'h1 << c;
         bus.cmd_amt   = 6'd20;
         bus.cmd_dir   = 1'b0;
         bus.cmd_valid = 1'b1;
         acc = bus.cmd_valid && bus.cmd_ready;
         step();
         if (acc) k++;
      end
      bus.cmd_valid = 1'b0;
      chk("mr_queued", 64'(k), 64'd4);
      chk("mr_busy_pre", 64'(bus.busy), 64'd1);
      #1 clr = 1'b0;
      #1;
      chk("mr_valid", 64'(bus.res_valid), 64'd0);
      chk("mr_busy",  64'(bus.busy),      64'd0);
      chk("mr_ready", 64'(bus.cmd_ready), 64'd1);
      chk("mr_data",  64'(bus.res_data),  64'd0);
      #2 clr = 1'b1;
      repeat (3) step();
      chk("mr_idle", 64'(bus.busy), 64'd0);
      run_one("mr_new", 32'h1, 6'd1, 1'b0, 32'h2, 2);

`ifdef SHIFT_ROTATE_EN
      bus.cmd_rot = 1'b1;
      run_one("rotr1",  32'h8000_0001, 6'd1,  1'b1, 32'hC000_0000, 2);
      run_one("rotl33", 32'h8000_0001, 6'd33, 1'b0, 32'h0000_0003, 2);
      run_one("rot32",  32'h8000_0001, 6'd32, 1'b0, 32'h8000_0001, 1);
      bus.cmd_rot = 1'b0;
`endif

      q.delete();
      sent = 0;
      recv = 0;
      cyc  = 0;
      m_rot = 1'b0;
      bus.cmd_valid = 1'b0;
      while ((sent < 400 || recv < 400) && cyc < 40000) begin
         bus.res_ready = ($urandom_range(0, 3) != 0);
         if (bus.res_valid && bus.res_ready) begin
            if (q.size() > 0) begin
               chk("rand_res", 64'(bus.res_data), 64'(q.pop_front()));
            end else begin
               chk("rand_extra", 64'(bus.res_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end
            recv++;
         end
         if (sent < 400 && !bus.cmd_valid && $urandom_range(0, 2) != 0) begin
            bus.cmd_data = $urandom();
            bus.cmd_amt  = ($urandom_range(0, 1) != 0) ?
                           6'($urandom_range(0, 8)) :
                           6'($urandom_range(0, 63));
            bus.cmd_dir  = 1'($urandom_range(0, 1));
`ifdef SHIFT_ROTATE_EN
            bus.cmd_rot  = 1'($urandom_range(0, 1));
            m_rot        = bus.cmd_rot;
`endif
            bus.cmd_valid = 1'b1;
         end
         acc = bus.cmd_valid && bus.cmd_ready;
         if (acc) begin
            q.push_back(ref_shift(bus.cmd_data, bus.cmd_amt,
                                  bus.cmd_dir, m_rot));
            sent++;
         end
         step();
         cyc++;
         if (acc) bus.cmd_valid = 1'b0;
      end
      chk("rand_sent", 64'(sent), 64'd400);
      chk("rand_recv", 64'(recv), 64'd400);
      chk("rand_left", 64'(q.size()), 64'd0);
      bus.res_ready = 1'b0;
      step();
      chk("rand_busy", 64'(bus.busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
